// File: rtl/lif_array_scheduler.sv
// ============================================================================
// Module      : lif_array_scheduler
// Description : Time-multiplexed leaky integrate-and-fire update across 2**IDX_W
//               neurons held in an internal register file, with valid/ready
//               current fetch and spike emission.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_array_scheduler #(
  parameter int             IDX_W    = 2,
  parameter logic [7:0]     THR_RST  = 8'd200,
  parameter logic [2:0]     LEAK_RST = 3'd1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_thr,
  input  logic [2:0]       cfg_leak,
  input  logic             cur_valid,
  input  logic [7:0]       cur_data,
  output logic             cur_ready,
  output logic [IDX_W-1:0] cur_idx,
  output logic             spk_valid,
  output logic [IDX_W-1:0] spk_id,
  input  logic             spk_ready,
  output logic             busy,
  output logic             done
);

  localparam int               c_N    = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] c_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_fsm;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_mem [c_N];
  logic [7:0]       r_thr;
  logic [2:0]       r_leak;
  logic             r_cur_ready;
  logic             r_spk_valid;
  logic [IDX_W-1:0] r_spk_id;
  logic             r_busy;
  logic             r_done;

  logic [7:0]       w_leaked;
  logic [8:0]       w_sum;
  logic [7:0]       w_sat;
  logic             w_fire;
  logic             w_last;
  logic             w_cur_hs;

  // Integration works on the freshly summed value, so the spike decision
  // sees the current input in the same cycle it is accepted.
  assign w_leaked = r_mem[r_idx] >> r_leak;
  assign w_sum    = {1'b0, cur_data} + {1'b0, w_leaked};
  assign w_sat    = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_fire   = (w_sat >= r_thr);
  assign w_last   = (r_idx == c_LAST);
  assign w_cur_hs = cur_valid && r_cur_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fsm       <= S_IDLE;
      r_idx       <= '0;
      r_thr       <= THR_RST;
      r_leak      <= LEAK_RST;
      r_cur_ready <= 1'b0;
      r_spk_valid <= 1'b0;
      r_spk_id    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < c_N; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (cfg_we) begin
            r_thr  <= cfg_thr;
            r_leak <= cfg_leak;
          end
          if (step) begin
            r_idx       <= '0;
            r_fsm       <= S_FETCH;
            r_cur_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end

        S_FETCH: begin
          if (w_cur_hs) begin
            if (w_fire) begin
              r_mem[r_idx] <= '0;
              r_spk_id     <= r_idx;
              r_spk_valid  <= 1'b1;
              r_cur_ready  <= 1'b0;
              r_fsm        <= S_EMIT;
            end else begin
              r_mem[r_idx] <= w_sat;
              if (w_last) begin
                r_cur_ready <= 1'b0;
                r_done      <= 1'b1;
                r_fsm       <= S_DONE;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
        end

        S_EMIT: begin
          // spk_id stays put until the router takes it; no timeout.
          if (spk_ready) begin
            r_spk_valid <= 1'b0;
            if (w_last) begin
              r_done <= 1'b1;
              r_fsm  <= S_DONE;
            end else begin
              r_idx       <= r_idx + 1'b1;
              r_cur_ready <= 1'b1;
              r_fsm       <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_fsm  <= S_IDLE;
        end

        default: begin
          r_fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign cur_ready = r_cur_ready;
  assign cur_idx   = r_idx;
  assign spk_valid = r_spk_valid;
  assign spk_id    = r_spk_id;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lif_array_scheduler.sv
// ============================================================================
// Module      : tb_lif_array_scheduler
// Description : Directed self-checking bench for lif_array_scheduler (N=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_array_scheduler;

  logic       clk;
  logic       reset_n;
  logic       step;
  logic       cfg_we;
  logic [7:0] cfg_thr;
  logic [2:0] cfg_leak;
  logic       cur_valid;
  logic [7:0] cur_data;
  logic       cur_ready;
  logic [1:0] cur_idx;
  logic       spk_valid;
  logic [1:0] spk_id;
  logic       spk_ready;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_err;

  // Reference state of the neuron array and configuration.
  logic [7:0] mdl [4];
  logic [7:0] m_thr;
  logic [2:0] m_leak;

  lif_array_scheduler #(
    .IDX_W    (2),
    .THR_RST  (8'd200),
    .LEAK_RST (3'd1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .step      (step),
    .cfg_we    (cfg_we),
    .cfg_thr   (cfg_thr),
    .cfg_leak  (cfg_leak),
    .cur_valid (cur_valid),
    .cur_data  (cur_data),
    .cur_ready (cur_ready),
    .cur_idx   (cur_idx),
    .spk_valid (spk_valid),
    .spk_id    (spk_id),
    .spk_ready (spk_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
    m_thr  = 8'd200;
    m_leak = 3'd1;
  endtask

  task automatic do_cfg(input logic [7:0] thr, input logic [2:0] leak);
    cfg_we   = 1'b1;
    cfg_thr  = thr;
    cfg_leak = leak;
    tick();
    cfg_we = 1'b0;
    m_thr  = thr;
    m_leak = leak;
  endtask

  // One neuron update of the reference: returns 1 when it spikes.
  function automatic logic mdl_update(input int i, input logic [7:0] d);
    logic [8:0] s;
    logic [7:0] sat;
    s   = {1'b0, d} + {1'b0, (mdl[i] >> m_leak)};
    sat = s[8] ? 8'hFF : s[7:0];
    if (sat >= m_thr) begin
      mdl[i] = 8'd0;
      return 1'b1;
    end
    mdl[i] = sat;
    return 1'b0;
  endfunction

  // Full sweep with the same current for every neuron, no stalls.
  task automatic do_sweep(input logic [7:0] d, input string tag);
    logic [7:0] exp_seq, got_seq;
    int         exp_cnt, got_cnt, cyc, dcyc;
    logic       got_done;
    exp_seq = '0;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (mdl_update(i, d)) begin
        exp_seq = {exp_seq[5:0], 2'(i)};
        exp_cnt++;
      end
    end
    step      = 1'b1;
    cur_data  = d;
    cur_valid = 1'b1;
    spk_ready = 1'b1;
    tick();
    step     = 1'b0;
    cyc      = 1;
    dcyc     = 0;
    got_seq  = '0;
    got_cnt  = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      if (spk_valid) begin
        got_seq = {got_seq[5:0], spk_id};
        got_cnt++;
      end
      if (done) begin
        got_done = 1'b1;
        dcyc     = cyc;
      end else begin
        tick();
        cyc++;
      end
    end
    cur_valid = 1'b0;
    check_eq({tag, " done_seen"}, 32'(got_done), 32'd1);
    check_eq({tag, " spk_count"}, 32'(got_cnt), 32'(exp_cnt));
    check_eq({tag, " spk_order"}, 32'(got_seq), 32'(exp_seq));
    check_eq({tag, " done_cycle"}, 32'(dcyc), 32'(5 + exp_cnt));
    tick();
    check_eq({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    int spk_seen;
    n_cmp     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    step      = 1'b0;
    cfg_we    = 1'b0;
    cfg_thr   = 8'd0;
    cfg_leak  = 3'd0;
    cur_valid = 1'b0;
    cur_data  = 8'd0;
    spk_ready = 1'b1;
    tick();

    // Reset defaults and threshold boundary
    do_reset();
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst cur_ready", 32'(cur_ready), 32'd0);
    check_eq("rst spk_valid", 32'(spk_valid), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst cur_idx", 32'(cur_idx), 32'd0);
    check_eq("rst spk_id", 32'(spk_id), 32'd0);
    do_sweep(8'd199, "thr199");
    do_reset();
    do_sweep(8'd200, "thr200");
    do_reset();
    do_sweep(8'd201, "thr201");

    // Integration with leak
    do_reset();
    do_sweep(8'd50, "int1");
    do_sweep(8'd50, "int2");
    do_sweep(8'd140, "int3");

    // Spiking and state reset
    do_reset();
    do_sweep(8'd150, "spk1");
    do_sweep(8'd150, "spk2");
    do_sweep(8'd150, "spk3");

    // Saturation, leak extremes, thr=0
    do_reset();
    do_cfg(8'd255, 3'd0);
    do_sweep(8'd200, "sat1");
    do_sweep(8'd200, "sat2");
    do_sweep(8'd254, "leak7a");
    do_cfg(8'd255, 3'd7);
    do_sweep(8'd254, "leak7b");
    do_cfg(8'd0, 3'd1);
    do_sweep(8'd0, "thr0");

    // Backpressure and fetch stall; only neuron 2 spikes
    do_reset();
    step      = 1'b1;
    cur_valid = 1'b0;
    spk_ready = 1'b0;
    tick();
    step = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("stall cur_ready", 32'(cur_ready), 32'd1);
      check_eq("stall cur_idx", 32'(cur_idx), 32'd0);
      tick();
    end
    cur_valid = 1'b1;
    cur_data  = 8'd10;
    tick();
    check_eq("bp idx1", 32'(cur_idx), 32'd1);
    tick();
    check_eq("bp idx2", 32'(cur_idx), 32'd2);
    cur_data = 8'd220;
    tick();
    cur_data = 8'd10;
    for (int k = 0; k < 5; k++) begin
      check_eq("bp spk_valid", 32'(spk_valid), 32'd1);
      check_eq("bp spk_id", 32'(spk_id), 32'd2);
      check_eq("bp cur_ready", 32'(cur_ready), 32'd0);
      tick();
    end
    spk_ready = 1'b1;
    tick();
    check_eq("bp resume idx", 32'(cur_idx), 32'd3);
    check_eq("bp resume ready", 32'(cur_ready), 32'd1);
    check_eq("bp resume spk_valid", 32'(spk_valid), 32'd0);
    tick();
    check_eq("bp done", 32'(done), 32'd1);
    cur_valid = 1'b0;
    tick();
    mdl[0] = 8'd10;
    mdl[1] = 8'd10;
    mdl[2] = 8'd0;
    mdl[3] = 8'd10;
    do_sweep(8'd195, "bp_after");

    // Ignored cfg_we and step mid-sweep
    do_reset();
    step      = 1'b1;
    cur_valid = 1'b0;
    tick();
    step     = 1'b0;
    cfg_we   = 1'b1;
    cfg_thr  = 8'd10;
    cfg_leak = 3'd0;
    tick();
    cfg_we    = 1'b0;
    step      = 1'b1;
    cur_valid = 1'b1;
    cur_data  = 8'd50;
    spk_ready = 1'b1;
    tick();
    step     = 1'b0;
    cyc      = 0;
    spk_seen = 0;
    while (!done && cyc < 40) begin
      if (spk_valid) spk_seen++;
      tick();
      cyc++;
    end
    check_eq("ign done_seen", 32'(done), 32'd1);
    check_eq("ign no_spike", 32'(spk_seen), 32'd0);
    cur_valid = 1'b0;
    tick();
    tick();
    tick();
    check_eq("ign no_extra_sweep", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) mdl[i] = 8'd50;
    do_sweep(8'd50, "ign_cfg");

    // Reset while in EMIT
    do_reset();
    do_sweep(8'd150, "abort_pre");
    step      = 1'b1;
    cur_valid = 1'b1;
    cur_data  = 8'd150;
    spk_ready = 1'b0;
    tick();
    step = 1'b0;
    tick();
    check_eq("abort in_emit", 32'(spk_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    check_eq("abort spk_valid", 32'(spk_valid), 32'd0);
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort cur_ready", 32'(cur_ready), 32'd0);
    reset_n   = 1'b1;
    cur_valid = 1'b0;
    spk_ready = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = 8'd0;
    m_thr  = 8'd200;
    m_leak = 3'd1;
    do_cfg(8'd1, 3'd1);
    do_sweep(8'd0, "abort_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
